// File: rtl/dwt_lift_ctrl.sv
// dwt_lift_ctrl: sequencing controller for one level of the 5/3 integer
// lifting DWT. Loads a frame of N_SAMPLES samples into the in-place sample
// memory, then issues every predict op, drains the ALU pipe, issues every
// update op, drains again and pulses done.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   abort            (only with DWT_LIFT_CTRL_ABORT_EN) synchronous frame abort
//   start            frame start, sampled only in IDLE
//   in_valid         input sample valid; in_ready high during LOAD
//   data_sel         write mux select: 0 external sample, 1 ALU result
//   mem_we/mem_waddr sample memory write port
//   raddr_c/l/r      centre / left / right read addresses of the issued op
//   alu_op           0 none, 1 predict, 2 update
//   busy, done       busy outside IDLE; done one-cycle pulse at completion
//
// Optional feature: define DWT_LIFT_CTRL_ABORT_EN to add the abort input.
module dwt_lift_ctrl #(
  parameter int unsigned N_SAMPLES = 8,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned ALU_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst,
`ifdef DWT_LIFT_CTRL_ABORT_EN
  input  logic              abort,
`endif
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              data_sel,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W-1:0] raddr_c,
  output logic [ADDR_W-1:0] raddr_l,
  output logic [ADDR_W-1:0] raddr_r,
  output logic [1:0]        alu_op,
  output logic              busy,
  output logic              done
);

  // Counter must reach N_SAMPLES-1 (load) and ALU_LAT-1 (drains, up to 3).
  localparam int unsigned K_W  = ADDR_W + 2;
  localparam int unsigned HALF = N_SAMPLES / 2;

  localparam logic [K_W-1:0] K_LOAD_LAST  = K_W'(N_SAMPLES - 1);
  localparam logic [K_W-1:0] K_OP_LAST    = K_W'(HALF - 1);
  localparam logic [K_W-1:0] K_DRAIN_LAST = K_W'(ALU_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PRED,
    S_DRAIN1,
    S_UPD,
    S_DRAIN2,
    S_DONE
  } state_t;

  state_t              state;
  logic [K_W-1:0]      k;
  logic [ALU_LAT-1:0]  wb_vld;
  logic [ADDR_W-1:0]   wb_addr [ALU_LAT];

  logic [K_W:0]        k2;
  logic                load_beat;
  logic                issue;
  logic                abort_req;
  logic                wb_out;

  assign k2        = {k, 1'b0};
  assign load_beat = (state == S_LOAD) && in_valid;
  assign issue     = (state == S_PRED) || (state == S_UPD);
  assign wb_out    = wb_vld[ALU_LAT-1];

`ifdef DWT_LIFT_CTRL_ABORT_EN
  assign abort_req = abort && (state != S_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  // State, phase counter and write-back pipe (valid + centre address).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      k      <= '0;
      wb_vld <= '0;
      for (int i = 0; i < ALU_LAT; i++) wb_addr[i] <= '0;
    end else begin
      wb_vld[0]  <= issue;
      wb_addr[0] <= raddr_c;
      for (int i = 1; i < ALU_LAT; i++) begin
        wb_vld[i]  <= wb_vld[i-1];
        wb_addr[i] <= wb_addr[i-1];
      end

      if (abort_req) begin
        // Abort discards the frame, including ops still in flight.
        state  <= S_IDLE;
        k      <= '0;
        wb_vld <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state <= S_LOAD;
              k     <= '0;
            end
          end
          S_LOAD: begin
            if (in_valid) begin
              if (k == K_LOAD_LAST) begin
                state <= S_PRED;
                k     <= '0;
              end else begin
                k <= k + K_W'(1);
              end
            end
          end
          S_PRED: begin
            if (k == K_OP_LAST) begin
              state <= S_DRAIN1;
              k     <= '0;
            end else begin
              k <= k + K_W'(1);
            end
          end
          S_DRAIN1: begin
            if (k == K_DRAIN_LAST) begin
              state <= S_UPD;
              k     <= '0;
            end else begin
              k <= k + K_W'(1);
            end
          end
          S_UPD: begin
            if (k == K_OP_LAST) begin
              state <= S_DRAIN2;
              k     <= '0;
            end else begin
              k <= k + K_W'(1);
            end
          end
          S_DRAIN2: begin
            if (k == K_DRAIN_LAST) begin
              state <= S_DONE;
              k     <= '0;
            end else begin
              k <= k + K_W'(1);
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            k     <= '0;
          end
          default: begin
            state <= S_IDLE;
            k     <= '0;
          end
        endcase
      end
    end
  end

  // Moore decode of state/k plus the write port (load beat or pipe output).
  always_comb begin
    alu_op    = 2'd0;
    raddr_c   = '0;
    raddr_l   = '0;
    raddr_r   = '0;
    in_ready  = (state == S_LOAD);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);

    case (state)
      S_PRED: begin
        alu_op  = 2'd1;
        raddr_c = ADDR_W'(k2 + (K_W+1)'(1));
        raddr_l = ADDR_W'(k2);
        // Right neighbour of the last odd sample mirrors back to N-2.
        raddr_r = (k == K_OP_LAST) ? ADDR_W'(N_SAMPLES - 2)
                                   : ADDR_W'(k2 + (K_W+1)'(2));
      end
      S_UPD: begin
        alu_op  = 2'd2;
        raddr_c = ADDR_W'(k2);
        raddr_r = ADDR_W'(k2 + (K_W+1)'(1));
        // Left neighbour of sample 0 mirrors to sample 1.
        raddr_l = (k == '0) ? ADDR_W'(1) : ADDR_W'(k2 - (K_W+1)'(1));
      end
      default: ;
    endcase

    // Load beats and pipe write-backs never coincide by schedule.
    mem_we    = wb_out | load_beat;
    data_sel  = wb_out;
    mem_waddr = wb_out    ? wb_addr[ALU_LAT-1] :
                load_beat ? ADDR_W'(k)         : '0;
  end

endmodule

// File: tb/tb_dwt_lift_ctrl.sv
module tb_dwt_lift_ctrl;

  localparam int N    = 8;
  localparam int AW   = 3;
  localparam int L    = 2;
  localparam int H    = N / 2;
  localparam int MAXC = 256;

  logic          clk;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          data_sel;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [AW-1:0] raddr_c;
  logic [AW-1:0] raddr_l;
  logic [AW-1:0] raddr_r;
  logic [1:0]    alu_op;
  logic          busy;
  logic          done;
`ifdef DWT_LIFT_CTRL_ABORT_EN
  logic          abort;
`endif

  int checks   = 0;
  int failures = 0;

  dwt_lift_ctrl #(.N_SAMPLES(N), .ADDR_W(AW), .ALU_LAT(L)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef DWT_LIFT_CTRL_ABORT_EN
    .abort     (abort),
`endif
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_sel  (data_sel),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .raddr_c   (raddr_c),
    .raddr_l   (raddr_l),
    .raddr_r   (raddr_r),
    .alu_op    (alu_op),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one frame starting at the current cycle (entered just after a rising
  // edge). Expected outputs for every cycle come from the frame schedule:
  // beats, then H predicts, L drain, H updates, L drain, done.
  // mode 0: in_valid always 1; mode 1: toggles 1,0,1,0 from cycle 0;
  // mode 2: random in_valid and random start pulses while busy.
  task automatic run_frame(input int mode, input bit hold_start, input int tail,
                           output int done_obs);
    bit v    [MAXC];
    bit e_we [MAXC];
    bit e_sel[MAXC];
    int e_wa [MAXC];
    int e_op [MAXC];
    int e_rc [MAXC];
    int e_rl [MAXC];
    int e_rr [MAXC];
    int beat_c [N];
    int beats, t_last, p0, u0, d_c, last, cc;
    bit e_busy, e_rdy, e_done;

    for (int c = 0; c < MAXC; c++) begin
      case (mode)
        0:       v[c] = 1'b1;
        1:       v[c] = (c % 2 == 0);
        default: v[c] = (c > 100) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      e_we[c] = 0; e_sel[c] = 0; e_wa[c] = 0;
      e_op[c] = 0; e_rc[c] = 0; e_rl[c] = 0; e_rr[c] = 0;
    end

    beats = 0;
    for (int c = 1; c < MAXC && beats < N; c++)
      if (v[c]) begin
        beat_c[beats] = c;
        beats++;
      end
    t_last = beat_c[N-1];
    for (int i = 0; i < N; i++) begin
      e_we[beat_c[i]] = 1;
      e_wa[beat_c[i]] = i;
    end

    p0 = t_last + 1;
    for (int j = 0; j < H; j++) begin
      cc = p0 + j;
      e_op[cc] = 1;
      e_rc[cc] = 2*j + 1;
      e_rl[cc] = 2*j;
      e_rr[cc] = (2*j + 2 == N) ? N - 2 : 2*j + 2;
      e_we[cc+L] = 1; e_sel[cc+L] = 1; e_wa[cc+L] = 2*j + 1;
    end
    u0 = p0 + H + L;
    for (int j = 0; j < H; j++) begin
      cc = u0 + j;
      e_op[cc] = 2;
      e_rc[cc] = 2*j;
      e_rr[cc] = 2*j + 1;
      e_rl[cc] = (j == 0) ? 1 : 2*j - 1;
      e_we[cc+L] = 1; e_sel[cc+L] = 1; e_wa[cc+L] = 2*j;
    end
    d_c  = u0 + H + L;
    last = d_c + tail;

    done_obs = -1;
    for (int c = 0; c <= last; c++) begin
      if (hold_start || c == 0) start = 1'b1;
      else if (mode == 2 && c <= d_c) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      in_valid = v[c];
      @(negedge clk);
      e_busy = (c >= 1 && c <= d_c);
      e_rdy  = (c >= 1 && c <= t_last);
      e_done = (c == d_c);
      if (done === 1'b1 && done_obs < 0) done_obs = c;

      checks++;
      if (busy !== e_busy) begin
        failures++;
        $display("FAIL busy cycle=%0d got=%b exp=%b", c, busy, e_busy);
      end
      checks++;
      if (in_ready !== e_rdy) begin
        failures++;
        $display("FAIL in_ready cycle=%0d got=%b exp=%b", c, in_ready, e_rdy);
      end
      checks++;
      if (done !== e_done) begin
        failures++;
        $display("FAIL done cycle=%0d got=%b exp=%b", c, done, e_done);
      end
      checks++;
      if (alu_op !== 2'(e_op[c])) begin
        failures++;
        $display("FAIL alu_op cycle=%0d got=%0d exp=%0d", c, alu_op, e_op[c]);
      end
      checks++;
      if ({raddr_c, raddr_l, raddr_r} !== {AW'(e_rc[c]), AW'(e_rl[c]), AW'(e_rr[c])}) begin
        failures++;
        $display("FAIL raddr cycle=%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)",
                 c, raddr_c, raddr_l, raddr_r, e_rc[c], e_rl[c], e_rr[c]);
      end
      checks++;
      if (mem_we !== e_we[c]) begin
        failures++;
        $display("FAIL mem_we cycle=%0d got=%b exp=%b", c, mem_we, e_we[c]);
      end
      checks++;
      if (data_sel !== e_sel[c]) begin
        failures++;
        $display("FAIL data_sel cycle=%0d got=%b exp=%b", c, data_sel, e_sel[c]);
      end
      if (e_we[c]) begin
        checks++;
        if (mem_waddr !== AW'(e_wa[c])) begin
          failures++;
          $display("FAIL mem_waddr cycle=%0d got=%0d exp=%0d", c, mem_waddr, e_wa[c]);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, in_ready, mem_we, data_sel, alu_op, mem_waddr, raddr_c, raddr_l, raddr_r} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0",
               {busy, done, in_ready, mem_we, data_sel, alu_op, mem_waddr, raddr_c, raddr_l, raddr_r});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, in_ready, mem_we} !== 4'b0) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=0000", {busy, done, in_ready, mem_we});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_nominal();
    int d;
    run_frame(0, 1'b0, 2, d);
    checks++;
    if (d !== 2*N + 2*L + 1) begin
      failures++;
      $display("FAIL nominal_done_cycle got=%0d exp=%0d", d, 2*N + 2*L + 1);
    end
  endtask

  task automatic test_load_stall();
    int d;
    run_frame(1, 1'b0, 2, d);
    checks++;
    if (d !== 2*N + 2*L + 1 + 8) begin
      failures++;
      $display("FAIL stall_done_cycle got=%0d exp=%0d", d, 2*N + 2*L + 9);
    end
  endtask

  task automatic test_random();
    int d;
    for (int f = 0; f < 4; f++) run_frame(2, 1'b0, 2, d);
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    run_frame(0, 1'b1, 0, d1);
    run_frame(0, 1'b0, 2, d2);
    checks++;
    if (d2 !== 2*N + 2*L + 1) begin
      failures++;
      $display("FAIL b2b_second_done got=%0d exp=%0d", d2, 2*N + 2*L + 1);
    end
  endtask

  task automatic test_reset_mid();
    int d;
    start = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    // Now in cycle 10: a predict op, with two write-backs pending.
    checks++;
    if (alu_op !== 2'd1) begin
      failures++;
      $display("FAIL rst_mid_precond alu_op got=%0d exp=1", alu_op);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, in_ready, mem_we, data_sel, alu_op, mem_waddr, raddr_c, raddr_l, raddr_r} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%b exp=0",
               {busy, done, in_ready, mem_we, data_sel, alu_op, mem_waddr, raddr_c, raddr_l, raddr_r});
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < L + 2; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_we, busy} !== 2'b00) begin
        failures++;
        $display("FAIL rst_mid_pending i=%0d got=%b exp=00", i, {mem_we, busy});
      end
    end
    @(posedge clk); #1;
    run_frame(0, 1'b0, 2, d);
  endtask

`ifdef DWT_LIFT_CTRL_ABORT_EN
  task automatic test_abort();
    int d;
    for (int c = 0; c <= 27; c++) begin
      start    = (c == 0);
      in_valid = 1'b1;
      abort    = (c == 16);
      @(negedge clk);
      if (c == 16) begin
        checks++;
        if (alu_op !== 2'd2) begin
          failures++;
          $display("FAIL abort_precond alu_op got=%0d exp=2", alu_op);
        end
      end
      if (c > 16) begin
        checks++;
        if ({busy, mem_we, done} !== 3'b000) begin
          failures++;
          $display("FAIL abort_idle cycle=%0d got=%b exp=000", c, {busy, mem_we, done});
        end
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    run_frame(0, 1'b0, 2, d);
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
`ifdef DWT_LIFT_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_nominal();
    test_load_stall();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef DWT_LIFT_CTRL_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dwt_lift_ctrl.md
# dwt_lift_ctrl

Sequencing controller for one level of the 5/3 integer lifting DWT. Accepts a frame of N samples into the in-place sample memory, then issues every predict and every update operation in order. It generates the memory read and write addresses, the ALU opcode and the `data_sel` for the 16-bit input/feedback mux that feeds the memory write port. Sits between the sample stream, the sample memory, the lifting ALU and the write mux.

## Interface
- `N_SAMPLES`, 8, frame length; even, ≥4
- `ADDR_W`, 3, address width; equals $clog2(N_SAMPLES)
- `ALU_LAT`, 2, cycles from op issue to write-back (memory read + ALU); 1..4

- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  frame start; sampled only in IDLE
- `in_valid`  in  1  input sample valid
- `in_ready`  out  1  controller accepts a sample
- `data_sel`  out  1  mux select: 0 = external sample, 1 = ALU result
- `mem_we`  out  1  sample memory write enable
- `mem_waddr`  out  ADDR_W  write address
- `raddr_c` / `raddr_l` / `raddr_r`  out  ADDR_W each  centre / left / right read addresses
- `alu_op`  out  2  0 = none, 1 = predict, 2 = update
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at frame completion

## Operation
- States: IDLE, LOAD, PRED, DRAIN1, UPD, DRAIN2, DONE. Counter `k` is cleared on every state entry.
- IDLE: `start` moves to LOAD. No other action.
- LOAD: `in_ready`=1. On each `in_valid` beat: `mem_we`=1, `data_sel`=0, `mem_waddr`=k, k++. After beat N_SAMPLES-1, go to PRED. `in_valid`=0 cycles are stalls.
- PRED: one op per cycle, k = 0..N/2-1; `alu_op`=1.
  - `raddr_c`=2k+1, `raddr_l`=2k.
  - `raddr_r`=2k+2, or N-2 when 2k+2=N (symmetric extension).
  - After the last op, go to DRAIN1.
- DRAIN1: held for exactly ALU_LAT cycles, `alu_op`=0, then UPD.
- UPD: k = 0..N/2-1; `alu_op`=2.
  - `raddr_c`=2k, `raddr_r`=2k+1.
  - `raddr_l`=2k-1, or 1 when k=0 (mirror).
  - After the last op, go to DRAIN2.
- DRAIN2: ALU_LAT cycles, then DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Write-back pipe:
  - An op issued in cycle c produces `mem_we`=1, `data_sel`=1 and `mem_waddr`=`raddr_c` of that op in cycle c+ALU_LAT.
  - The pipe is a shift register of valid bit + address, ALU_LAT deep.
  - Load writes and pipe writes never overlap, by construction.
- When `alu_op`=0, the read addresses are 0.
- `data_sel`=0 whenever `mem_we`=0.

## Timing
- Reset value of all outputs: 0. Reset clears state, counter and the write-back pipe. Reset mid-frame discards the frame; pending write-backs are suppressed.
- Addresses and `alu_op` are Moore outputs of registered state and k, valid in the issue cycle.
- Memory write is committed at the clock edge of cycle c+ALU_LAT. The drains guarantee that an update read of an odd sample happens at least one cycle after that sample's predict write.
- Cycle budget, with `start` sampled in cycle 0 and no stalls:
  - LOAD: 1..N
  - PRED: N/2
  - DRAIN1: ALU_LAT
  - UPD: N/2
  - DRAIN2: ALU_LAT
  - `done` in cycle 2N+2·ALU_LAT+1
- `start` outside IDLE is ignored.
- `start` held high through DONE begins a new frame only after IDLE is re-entered, so the earliest restart is one cycle after `done`.

## Configuration
- `DWT_LIFT_CTRL_ABORT_EN` defined:
  - Adds input port `abort` (1 bit, synchronous).
  - `abort`=1 in any non-IDLE state forces IDLE on the next edge and clears the write-back pipe; no further `mem_we` is issued.
  - `done` is not pulsed.
  - `abort` has priority over state progress and over `start`.
- Not defined: the port is absent and frames always run to completion.

## Test plan
- N=8, ALU_LAT=2: `start`, then 8 consecutive beats → `done` in cycle 21; `busy` high cycles 1..21.
- PRED address check → (c,l,r) = (1,0,2), (3,2,4), (5,4,6), (7,6,6). UPD → (0,1,1), (2,1,3), (4,3,5), (6,5,7).
- Write-back: PRED op issued cycle 9 → `mem_we`=1, `data_sel`=1, `mem_waddr`=1 in cycle 11. No write in cycles 15–16 apart from the drained predict writes completing by 14.
- LOAD with `in_valid` toggled 1,0,1,0… → exactly 8 writes with addresses 0..7; `done` delayed by 8 cycles (cycle 29).
- `rst` pulsed during PRED → all outputs 0 immediately. No `mem_we` from pending ops. The next `start` loads from address 0.
- With `DWT_LIFT_CTRL_ABORT_EN`: `abort` in cycle 16 (UPD) → IDLE in cycle 17, no `mem_we` after cycle 16, no `done`.
